// File: rtl/grad_ctrl_pkg.sv
// Shared types and geometry helpers for the gradient stage controller.
// Default-geometry constants describe the 640x480 build; the top recomputes them from its parameters.
package grad_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, FETCH, EMIT, DONE} state_t;
  typedef logic [1:0] grad_shift_t;

  localparam int DEF_IMG_W    = 640;
  localparam int DEF_IMG_H    = 480;
  localparam int DEF_WIN      = 7;
  localparam int DEF_OUT_ROWS = 5;

  // Strips needed to cover the IMG_H-2 valid output rows.
  function automatic int nstrip_f(input int img_h, input int out_rows);
    return (img_h - 2 + out_rows - 1) / out_rows;
  endfunction

  function automatic int last_rows_f(input int img_h, input int out_rows);
    return (img_h - 2) - (nstrip_f(img_h, out_rows) - 1) * out_rows;
  endfunction

  localparam int NSTRIP    = nstrip_f(DEF_IMG_H, DEF_OUT_ROWS);
  localparam int LAST_ROWS = last_rows_f(DEF_IMG_H, DEF_OUT_ROWS);
  localparam int COL_W     = $clog2(DEF_IMG_W);
  localparam int ROW_W     = $clog2(DEF_IMG_H);

endpackage

// File: rtl/gradient_stage_controller.sv
// Frame sequencer for the gradient/magnitude datapath: strip scan, column fetch, result handshake.
// Optional GRAD_CTRL_PERF_EN adds a saturating stall-cycle counter output.
module gradient_stage_controller
  import grad_ctrl_pkg::*;
#(
  parameter int IMG_W    = DEF_IMG_W,
  parameter int IMG_H    = DEF_IMG_H,
  parameter int WIN      = DEF_WIN,
  parameter int OUT_ROWS = DEF_OUT_ROWS
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       start,
  input  grad_shift_t                grad_shift_in,
  output logic                       busy,
  output logic                       done,
  output logic                       col_req,
  input  logic                       col_ack,
  output logic [$clog2(IMG_H)-1:0]   col_row_base,
  output logic [$clog2(IMG_W)-1:0]   col_idx,
  output logic                       win_shift,
  output grad_shift_t                grad_shift,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(IMG_H)-1:0]   out_row,
  output logic [$clog2(IMG_W)-1:0]   out_col,
  output logic [OUT_ROWS-1:0]        out_row_mask
`ifdef GRAD_CTRL_PERF_EN
  ,output logic [31:0]               stall_cycles
`endif
);

  localparam int CW        = $clog2(IMG_W);
  localparam int RW        = $clog2(IMG_H);
  localparam int CNT_W     = $clog2(IMG_W + 1);
  localparam int N_STRIPS  = nstrip_f(IMG_H, OUT_ROWS);
  localparam int TAIL_ROWS = last_rows_f(IMG_H, OUT_ROWS);
  localparam int STRIP_W   = (N_STRIPS > 1) ? $clog2(N_STRIPS) : 1;

  localparam logic [CNT_W-1:0]    WIN_M1    = CNT_W'(WIN - 1);
  localparam logic [CNT_W-1:0]    IMG_W_C   = CNT_W'(IMG_W);
  localparam logic [CNT_W-1:0]    HALF      = CNT_W'(WIN / 2);
  localparam logic [RW-1:0]       ROW_STEP  = RW'(OUT_ROWS);
  localparam logic [STRIP_W-1:0]  LAST_S    = STRIP_W'(N_STRIPS - 1);
  localparam logic [OUT_ROWS-1:0] TAIL_MASK = OUT_ROWS'((1 << TAIL_ROWS) - 1);

  state_t              state;
  logic [CNT_W-1:0]    col_cnt;
  logic [STRIP_W-1:0]  strip;
  logic                last_strip;

  assign last_strip = (strip == LAST_S);
  assign col_idx    = CW'(col_cnt);
  assign win_shift  = col_req & col_ack;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      col_req      <= 1'b0;
      out_valid    <= 1'b0;
      grad_shift   <= '0;
      col_cnt      <= '0;
      strip        <= '0;
      col_row_base <= '0;
      out_row      <= '0;
      out_col      <= '0;
      out_row_mask <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            grad_shift   <= grad_shift_in;
            col_cnt      <= '0;
            strip        <= '0;
            col_row_base <= '0;
            busy         <= 1'b1;
            col_req      <= 1'b1;
            state        <= FETCH;
          end
        end
        FETCH: begin
          if (col_ack) begin
            col_cnt <= col_cnt + CNT_W'(1);
            // Window full once this ack brings the strip to WIN columns.
            if (col_cnt >= WIN_M1) begin
              col_req      <= 1'b0;
              out_valid    <= 1'b1;
              out_col      <= CW'(col_cnt - HALF);
              out_row      <= col_row_base + RW'(1);
              out_row_mask <= last_strip ? TAIL_MASK : '1;
              state        <= EMIT;
            end
          end
        end
        EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (col_cnt != IMG_W_C) begin
              col_req <= 1'b1;
              state   <= FETCH;
            end else if (last_strip) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= DONE;
            end else begin
              strip        <= strip + STRIP_W'(1);
              col_cnt      <= '0;
              col_row_base <= col_row_base + ROW_STEP;
              col_req      <= 1'b1;
              state        <= FETCH;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef GRAD_CTRL_PERF_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      stall_cycles <= '0;
    end else if (state == IDLE && start) begin
      stall_cycles <= '0;
    end else if (((col_req & ~col_ack) | (out_valid & ~out_ready)) && stall_cycles != '1) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gradient_stage_controller.sv
// Directed bench for gradient_stage_controller with a 10x9 image (2 strips, 2 rows on the last).
module tb_gradient_stage_controller;

  logic        clk;
  logic        n_rst;
  logic        start;
  logic [1:0]  grad_shift_in;
  logic        busy, done, col_req, col_ack, win_shift, out_valid, out_ready;
  logic [3:0]  col_row_base, col_idx, out_row, out_col;
  logic [1:0]  grad_shift;
  logic [4:0]  out_row_mask;
`ifdef GRAD_CTRL_PERF_EN
  logic [31:0] stall_cycles;
`endif

  int checks = 0;
  int errors = 0;
  int nshift, nemit, ndone;
  bit aborted;

  gradient_stage_controller #(.IMG_W(10), .IMG_H(9), .WIN(7), .OUT_ROWS(5)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .grad_shift_in(grad_shift_in),
    .busy(busy), .done(done), .col_req(col_req), .col_ack(col_ack),
    .col_row_base(col_row_base), .col_idx(col_idx), .win_shift(win_shift),
    .grad_shift(grad_shift), .out_valid(out_valid), .out_ready(out_ready),
    .out_row(out_row), .out_col(out_col), .out_row_mask(out_row_mask)
`ifdef GRAD_CTRL_PERF_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_frame(input logic [1:0] g);
    grad_shift_in = g;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    grad_shift_in = 2'd0;
    check("start_busy", busy, 1);
    check("start_req", col_req, 1);
    check("start_gs", grad_shift, g);
    check("start_idx", col_idx, 0);
    check("start_base", col_row_base, 0);
  endtask

  // Reactive frame driver: acks fetches after ack_dly waiting cycles, accepts results,
  // optionally stalls one emit, pulses a stray start, or resets mid strip 1.
  task automatic run_frame(input int ack_dly, input int stall_emit, input int stall_len,
                           input int mid_start, input bit abort);
    int wait_c = 0;
    int stall_c = 0;
    logic [31:0] last_idx = 0;
    logic [31:0] held_col = 0;
    logic exp_ws;
    bit fin = 0;
    nshift = 0; nemit = 0; ndone = 0; aborted = 0;
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      col_ack = 1'b0; out_ready = 1'b0; start = 1'b0; exp_ws = 1'b0;
      if (cyc == mid_start) begin
        start = 1'b1;
        grad_shift_in = 2'd1;
      end
      if (abort && nemit == 4 && col_req) begin
        start = 1'b0;
        n_rst = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_req", col_req, 0);
        check("abort_valid", out_valid, 0);
        check("abort_ws", win_shift, 0);
        check("abort_gs", grad_shift, 0);
        check("abort_base", col_row_base, 0);
        n_rst = 1'b1;
        aborted = 1;
        @(negedge clk);
        return;
      end
      if (out_valid) begin
        check("emit_noreq", col_req, 0);
        if (nemit == stall_emit && stall_c < stall_len) begin
          if (stall_c == 0) held_col = 32'(out_col);
          else check("bp_col_hold", out_col, held_col);
          col_ack = 1'b1;  // stray ack outside FETCH must not shift
          stall_c++;
        end else begin
          out_ready = 1'b1;
          check("emit_col", out_col, 3 + nemit % 4);
          check("emit_row", out_row, (nemit < 4) ? 1 : 6);
          check("emit_mask", out_row_mask, (nemit < 4) ? 5'b11111 : 5'b00011);
          nemit++;
        end
      end else if (col_req) begin
        if (wait_c == 0) last_idx = 32'(col_idx);
        else check("idx_hold", col_idx, last_idx);
        if (wait_c == ack_dly) begin
          col_ack = 1'b1;
          exp_ws = 1'b1;
          wait_c = 0;
        end else begin
          wait_c++;
        end
      end
      if (done) begin
        check("done_busy", busy, 0);
        ndone++;
        fin = 1;
      end
      #1;
      check("win_shift", win_shift, exp_ws);
      if (win_shift) nshift++;
      @(negedge clk);
    end
    col_ack = 1'b0; out_ready = 1'b0; start = 1'b0;
    check("frame_done_seen", fin, 1);
  endtask

  initial begin
    n_rst = 1'b0; start = 1'b0; grad_shift_in = 2'd0; col_ack = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);

    // 1. reset state
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_req", col_req, 0);
    check("rst_valid", out_valid, 0);
    check("rst_ws", win_shift, 0);
    check("rst_gs", grad_shift, 0);
    check("rst_mask", out_row_mask, 0);
    n_rst = 1'b1;
    @(negedge clk);
    check("idle_busy", busy, 0);

    // 2. full frame, ack one cycle after request
    start_frame(2'd3);
    run_frame(1, -1, 0, -1, 0);
    check("f2_shifts", nshift, 20);
    check("f2_emits", nemit, 8);
    check("f2_done", ndone, 1);
    check("f2_done_pulse", done, 0);
    check("f2_busy", busy, 0);

    // 3. backpressure on second emit, immediate acks
    start_frame(2'd0);
    run_frame(0, 1, 5, -1, 0);
    check("f3_shifts", nshift, 20);
    check("f3_emits", nemit, 8);
`ifdef GRAD_CTRL_PERF_EN
    check("f3_stall_cycles", stall_cycles, 5);
`endif

    // 4. slow source, ack after 3 waiting cycles
    start_frame(2'd1);
    run_frame(3, -1, 0, -1, 0);
    check("f4_shifts", nshift, 20);
    check("f4_emits", nemit, 8);

    // 5. second start mid-frame is ignored
    start_frame(2'd2);
    run_frame(1, -1, 0, 10, 0);
    check("f5_gs", grad_shift, 2);
    check("f5_done", ndone, 1);
    check("f5_emits", nemit, 8);

    // 6. reset during strip 1 fetch, then a clean frame
    start_frame(2'd1);
    run_frame(1, -1, 0, -1, 1);
    check("f6_aborted", aborted, 1);
    start_frame(2'd0);
    run_frame(1, -1, 0, -1, 0);
    check("f6_shifts", nshift, 20);
    check("f6_emits", nemit, 8);
    check("f6_done", ndone, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
